// File: rtl/sha1_pkg.sv
// Shared types, constants and helpers for the SHA-1 message writer.
package sha1_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StPad,
        StLenHi,
        StLenLo,
        StDone
    } sha1_state_e;

    localparam logic [7:0]  PAD_BYTE    = 8'h80;
    localparam int unsigned BLOCK_BYTES = 64;
    localparam int unsigned LEN_OFFSET  = 56;

    // Reverse byte order: the length words are stored big-endian in a little-endian buffer.
    function automatic logic [31:0] byteswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Padded byte count (excluding the 8 length bytes) for a message of len bytes.
    function automatic logic [31:0] calc_pad_len(input logic [31:0] len);
        logic [31:0] rem;
        logic [31:0] blk_base;
        rem      = (len + 32'd1) % BLOCK_BYTES;
        blk_base = (len / BLOCK_BYTES) * BLOCK_BYTES;
        if ((rem != 32'd0) && (rem <= LEN_OFFSET)) begin
            return blk_base + LEN_OFFSET;
        end
        return blk_base + BLOCK_BYTES + LEN_OFFSET;
    endfunction

endpackage

// File: rtl/sha1_msg_writer_if.sv
// Byte-stream input and DPSRAM port A of the SHA-1 message writer.
interface sha1_msg_writer_if;

    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_last;
    logic        byte_ready;

    logic        port_A_clk;
    logic [15:0] port_A_addr;
    logic [31:0] port_A_data_in;
    logic        port_A_we;

    // Writer side: consumes bytes, drives the memory port.
    modport master (
        input  byte_valid, byte_data, byte_last,
        output byte_ready, port_A_clk, port_A_addr, port_A_data_in, port_A_we
    );

    // Environment side: produces bytes, observes the memory port.
    modport slave (
        output byte_valid, byte_data, byte_last,
        input  byte_ready, port_A_clk, port_A_addr, port_A_data_in, port_A_we
    );

endinterface

// File: rtl/sha1_byte_packer.sv
// Little-endian byte-to-word packer: tracks the lane index and the partial word.
module sha1_byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_data,
    output logic [1:0]  lane,
    output logic [31:0] word_next,
    output logic        word_full
);

    logic [1:0]  lane_q;
    logic [31:0] acc_q;

    // Merge the incoming byte into its lane; lane 0 starts a fresh word so upper lanes read zero.
    always_comb begin
        word_next = (lane_q == 2'd0) ? 32'd0 : acc_q;
        case (lane_q)
            2'd0:    word_next[7:0]   = byte_data;
            2'd1:    word_next[15:8]  = byte_data;
            2'd2:    word_next[23:16] = byte_data;
            default: word_next[31:24] = byte_data;
        endcase
    end

    assign lane      = lane_q;
    assign word_full = accept && (lane_q == 2'd3);

    // Advance the lane and keep the merged word on every accepted byte.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            lane_q <= 2'd0;
            acc_q  <= 32'd0;
        end else if (accept) begin
            lane_q <= lane_q + 2'd1;
            acc_q  <= word_next;
        end
    end

endmodule

// File: rtl/sha1_msg_writer.sv
// Writes a byte stream into DPSRAM as little-endian words, optionally followed by SHA-1
// padding and the 64-bit big-endian bit length.
module sha1_msg_writer
    import sha1_pkg::*;
#(
    parameter bit PAD_EN = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       base_addr,
    sha1_msg_writer_if.master bus,
    output logic [31:0]       msg_size,
    output logic [31:0]       pad_len,
    output logic              done,
    output logic              addr_err
);

    sha1_state_e state_q, state_d;
    logic        last_q, last_d;        // last byte taken; its word is being written now
    logic        wr_q, wr_d;            // packed word pending for this cycle
    logic [31:0] wr_data_q, wr_data_d;
    logic        need80_q, need80_d;    // message ended on a word boundary
    logic [29:0] word_idx_q, word_idx_d;
    logic [15:0] base_q, base_d;
    logic [31:0] msg_size_q, msg_size_d;
    logic [31:0] pad_len_q, pad_len_d;
    logic        done_q, done_d;
    logic        addr_err_q, addr_err_d;

    logic        load_ready;
    logic        accept;
    logic        packer_clear;
    logic [1:0]  lane;
    logic [31:0] word_next;
    logic [31:0] padded;
    logic        word_full;
    logic        we;
    logic [31:0] wdata;
    logic        unused_base_hi;

    assign unused_base_hi = ^base_addr[31:16];
    assign load_ready     = (state_q == StLoad) && !last_q;
    assign accept         = bus.byte_valid && load_ready;

    sha1_byte_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (packer_clear),
        .accept    (accept),
        .byte_data (bus.byte_data),
        .lane      (lane),
        .word_next (word_next),
        .word_full (word_full)
    );

    // Final partial word gets the 0x80 marker in the lane after the last byte.
    always_comb begin
        padded = word_next;
        case (lane)
            2'd0:    padded[15:8]  = PAD_BYTE;
            2'd1:    padded[23:16] = PAD_BYTE;
            2'd2:    padded[31:24] = PAD_BYTE;
            default: padded        = word_next;
        endcase
    end

    // Next-state, write strobe and write data.
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        wr_d         = 1'b0;
        wr_data_d    = wr_data_q;
        need80_d     = need80_q;
        word_idx_d   = word_idx_q;
        base_d       = base_q;
        msg_size_d   = msg_size_q;
        pad_len_d    = pad_len_q;
        done_d       = done_q;
        addr_err_d   = addr_err_q;
        packer_clear = 1'b0;
        we           = 1'b0;
        wdata        = 32'd0;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    done_d     = 1'b0;
                    msg_size_d = 32'd0;
                    pad_len_d  = 32'd0;
                    if (base_addr[1:0] != 2'b00) begin
                        addr_err_d = 1'b1;
                        state_d    = StIdle;
                    end else begin
                        addr_err_d   = 1'b0;
                        state_d      = StLoad;
                        base_d       = base_addr[15:0];
                        word_idx_d   = 30'd0;
                        last_d       = 1'b0;
                        need80_d     = 1'b0;
                        packer_clear = 1'b1;
                    end
                end
            end
            StLoad: begin
                we    = wr_q;
                wdata = wr_data_q;
                if (accept) begin
                    msg_size_d = msg_size_q + 32'd1;
                    if (bus.byte_last) begin
                        wr_d      = 1'b1;
                        wr_data_d = PAD_EN ? padded : word_next;
                        last_d    = 1'b1;
                        if (PAD_EN) begin
                            pad_len_d = calc_pad_len(msg_size_q + 32'd1);
                            need80_d  = (lane == 2'd3);
                        end
                    end else if (word_full) begin
                        wr_d      = 1'b1;
                        wr_data_d = word_next;
                    end
                end
                // The cycle after the last byte flushes its word, then the message body is over.
                if (last_q) begin
                    last_d  = 1'b0;
                    state_d = PAD_EN ? StPad : StDone;
                    done_d  = !PAD_EN;
                end
            end
            StPad: begin
                if (word_idx_q < pad_len_q[31:2]) begin
                    we       = 1'b1;
                    wdata    = need80_q ? {24'd0, PAD_BYTE} : 32'd0;
                    need80_d = 1'b0;
                    if (word_idx_q == pad_len_q[31:2] - 30'd1) begin
                        state_d = StLenHi;
                    end
                end else begin
                    state_d = StLenHi;
                end
            end
            StLenHi: begin
                we      = 1'b1;
                wdata   = byteswap({29'd0, msg_size_q[31:29]});
                state_d = StLenLo;
            end
            StLenLo: begin
                we      = 1'b1;
                wdata   = byteswap({msg_size_q[28:0], 3'b000});
                state_d = StDone;
                done_d  = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        if (we) begin
            word_idx_d = word_idx_q + 30'd1;
        end
    end

    assign bus.byte_ready     = load_ready;
    assign bus.port_A_clk     = clk;
    assign bus.port_A_we      = we;
    assign bus.port_A_data_in = we ? wdata : 32'd0;
    assign bus.port_A_addr    = we ? (base_q + {word_idx_q[13:0], 2'b00}) : 16'd0;
    assign msg_size           = msg_size_q;
    assign pad_len            = pad_len_q;
    assign done               = done_q;
    assign addr_err           = addr_err_q;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            last_q     <= 1'b0;
            wr_q       <= 1'b0;
            wr_data_q  <= 32'd0;
            need80_q   <= 1'b0;
            word_idx_q <= 30'd0;
            base_q     <= 16'd0;
            msg_size_q <= 32'd0;
            pad_len_q  <= 32'd0;
            done_q     <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            wr_q       <= wr_d;
            wr_data_q  <= wr_data_d;
            need80_q   <= need80_d;
            word_idx_q <= word_idx_d;
            base_q     <= base_d;
            msg_size_q <= msg_size_d;
            pad_len_q  <= pad_len_d;
            done_q     <= done_d;
            addr_err_q <= addr_err_d;
        end
    end

endmodule

// File: tb/tb_sha1_msg_writer.sv
// Directed bench: one padding writer (PAD_EN=1) and one raw writer (PAD_EN=0) in lockstep.
module tb_sha1_msg_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] base_addr;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_last;

    logic [31:0] msg_size_p, pad_len_p, msg_size_r, pad_len_r;
    logic        done_p, addr_err_p, done_r, addr_err_r;

    always #5 clk = ~clk;

    sha1_msg_writer_if bus_p ();
    sha1_msg_writer_if bus_r ();

    assign bus_p.byte_valid = byte_valid;
    assign bus_p.byte_data  = byte_data;
    assign bus_p.byte_last  = byte_last;
    assign bus_r.byte_valid = byte_valid;
    assign bus_r.byte_data  = byte_data;
    assign bus_r.byte_last  = byte_last;

    sha1_msg_writer #(.PAD_EN(1'b1)) dut_p (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .bus       (bus_p),
        .msg_size  (msg_size_p),
        .pad_len   (pad_len_p),
        .done      (done_p),
        .addr_err  (addr_err_p)
    );

    sha1_msg_writer #(.PAD_EN(1'b0)) dut_r (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .bus       (bus_r),
        .msg_size  (msg_size_r),
        .pad_len   (pad_len_r),
        .done      (done_r),
        .addr_err  (addr_err_r)
    );

    logic [7:0]  msg [0:255];
    logic [31:0] log_p_data [0:1023];
    logic [15:0] log_p_addr [0:1023];
    logic [31:0] log_r_data [0:1023];
    logic [31:0] wexp [0:29];
    int          tot_p = 0;
    int          tot_r = 0;
    int          mark_p, mark_r;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] w;

    // Write logger for both memory ports.
    always @(negedge clk) begin
        if (bus_p.port_A_we === 1'b1) begin
            if (tot_p < 1024) begin
                log_p_data[tot_p] <= bus_p.port_A_data_in;
                log_p_addr[tot_p] <= bus_p.port_A_addr;
            end
            tot_p <= tot_p + 1;
        end
        if (bus_r.port_A_we === 1'b1) begin
            if (tot_r < 1024) log_r_data[tot_r] <= bus_r.port_A_data_in;
            tot_r <= tot_r + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] pw(input int j);
        return log_p_data[mark_p + j];
    endfunction

    function automatic logic [31:0] rw(input int j);
        return log_r_data[mark_r + j];
    endfunction

    function automatic logic [31:0] msg_word(input int j);
        return {msg[4*j+3], msg[4*j+2], msg[4*j+1], msg[4*j]};
    endfunction

    task automatic mark();
        mark_p = tot_p;
        mark_r = tot_r;
    endtask

    task automatic do_start(input logic [31:0] base);
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = base;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic send_bytes(input int first, input int n, input bit gaps, input bit mark_last);
        int t;
        bit taken;
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                byte_valid = 1'b0;
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk); #1;
                end
            end
            byte_valid = 1'b1;
            byte_data  = msg[first + i];
            byte_last  = mark_last && (i == n - 1);
            t     = 0;
            taken = 1'b0;
            while (!taken && t < 50) begin
                @(negedge clk);
                taken = (bus_p.byte_ready === 1'b1);
                @(posedge clk); #1;
                t++;
            end
            if (!taken) begin
                check("byte_accept_timeout", 32'(taken), 32'd1);
                break;
            end
        end
        byte_valid = 1'b0;
        byte_last  = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        while (!(done_p === 1'b1 && done_r === 1'b1) && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        check(tag, 32'(done_p & done_r), 32'd1);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        base_addr  = 32'd0;
        byte_valid = 1'b0;
        byte_data  = 8'd0;
        byte_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_byte_ready", 32'(bus_p.byte_ready), 32'd0);
        check("rst_we", 32'(bus_p.port_A_we), 32'd0);
        check("rst_addr", 32'(bus_p.port_A_addr), 32'd0);
        check("rst_data", bus_p.port_A_data_in, 32'd0);
        check("rst_msg_size", msg_size_p, 32'd0);
        check("rst_pad_len", pad_len_p, 32'd0);
        check("rst_done", 32'(done_p), 32'd0);
        check("rst_addr_err", 32'(addr_err_p), 32'd0);
        reset = 1'b0;

        // L=1, byte 0x67, base 0
        msg[0] = 8'h67;
        mark();
        do_start(32'h0);
        send_bytes(0, 1, 1'b0, 1'b1);
        wait_done("l1_done");
        check("l1_writes", 32'(tot_p - mark_p), 32'd16);
        check("l1_word0", pw(0), 32'h0000_8067);
        for (int j = 1; j < 15; j++) check($sformatf("l1_word%0d", j), pw(j), 32'd0);
        check("l1_word15", pw(15), 32'h0800_0000);
        check("l1_addr15", 32'(log_p_addr[mark_p + 15]), 32'd60);
        check("l1_pad_len", pad_len_p, 32'd56);
        check("l1_msg_size", msg_size_p, 32'd1);
        check("l1_raw_writes", 32'(tot_r - mark_r), 32'd1);
        check("l1_raw_word0", rw(0), 32'h0000_0067);

        // L=120 from rotate-left word sequence, base 0x100; start from DONE clears status
        w = 32'h0123_4567;
        for (int i = 0; i < 30; i++) begin
            wexp[i] = w;
            for (int k = 0; k < 4; k++) msg[4*i+k] = w[8*k +: 8];
            w = {w[30:0], w[31]};
        end
        mark();
        do_start(32'h100);
        check("l120_done_cleared", 32'(done_p), 32'd0);
        check("l120_size_cleared", msg_size_p, 32'd0);
        send_bytes(0, 120, 1'b0, 1'b1);
        wait_done("l120_done");
        check("l120_writes", 32'(tot_p - mark_p), 32'd48);
        check("l120_word0", pw(0), wexp[0]);
        check("l120_word29", pw(29), wexp[29]);
        check("l120_word30", pw(30), 32'h0000_0080);
        for (int j = 31; j < 47; j++) check($sformatf("l120_word%0d", j), pw(j), 32'd0);
        check("l120_word47", pw(47), 32'hC003_0000);
        check("l120_addr0", 32'(log_p_addr[mark_p]), 32'h100);
        check("l120_addr47", 32'(log_p_addr[mark_p + 47]), 32'h1BC);
        check("l120_pad_len", pad_len_p, 32'd184);

        // L=55, base 0x200, with a stray start in the middle of the body
        for (int i = 0; i < 64; i++) msg[i] = 8'(i);
        mark();
        do_start(32'h200);
        send_bytes(0, 10, 1'b0, 1'b0);
        do_start(32'h40);
        send_bytes(10, 45, 1'b0, 1'b1);
        wait_done("l55_done");
        check("l55_writes", 32'(tot_p - mark_p), 32'd16);
        check("l55_word13", pw(13), 32'h8036_3534);
        check("l55_word14", pw(14), 32'd0);
        check("l55_word15", pw(15), 32'hB801_0000);
        check("l55_addr0", 32'(log_p_addr[mark_p]), 32'h200);
        check("l55_addr15", 32'(log_p_addr[mark_p + 15]), 32'h23C);
        check("l55_msg_size", msg_size_p, 32'd55);
        check("l55_pad_len", pad_len_p, 32'd56);
        check("l55_raw_word13", rw(13), 32'h0036_3534);

        // L=56 spills the length into a second block
        mark();
        do_start(32'h0);
        send_bytes(0, 56, 1'b0, 1'b1);
        wait_done("l56_done");
        check("l56_writes", 32'(tot_p - mark_p), 32'd32);
        check("l56_word13", pw(13), 32'h3736_3534);
        check("l56_word14", pw(14), 32'h0000_0080);
        check("l56_word15", pw(15), 32'd0);
        check("l56_word31", pw(31), 32'hC001_0000);
        check("l56_pad_len", pad_len_p, 32'd120);

        // L=64 without and with gaps in byte_valid
        for (int i = 0; i < 64; i++) msg[i] = 8'(i * 7 + 3);
        for (int pass = 0; pass < 2; pass++) begin
            mark();
            do_start(32'h0);
            send_bytes(0, 64, pass == 1, 1'b1);
            wait_done($sformatf("l64_done_gap%0d", pass));
            check($sformatf("l64_writes_gap%0d", pass), 32'(tot_p - mark_p), 32'd32);
            for (int j = 0; j < 32; j++) begin
                if (pass == 1 || j == 0 || j >= 15) begin
                    check($sformatf("l64_gap%0d_word%0d", pass, j), pw(j),
                          (j < 16) ? msg_word(j) : (j == 16) ? 32'h80 :
                          (j == 31) ? 32'h0002_0000 : 32'd0);
                end
            end
        end

        // Misaligned base: error flag, no write, back to idle
        mark();
        do_start(32'h2);
        check("aerr_flag", 32'(addr_err_p), 32'd1);
        check("aerr_done", 32'(done_p), 32'd0);
        check("aerr_ready", 32'(bus_p.byte_ready), 32'd0);
        repeat (10) @(posedge clk);
        #1;
        check("aerr_no_write", 32'(tot_p - mark_p), 32'd0);

        // L=5: raw writer gives exactly 2 words; next good start clears addr_err
        for (int i = 0; i < 5; i++) msg[i] = 8'hb0 + 8'(i);
        mark();
        do_start(32'h0);
        check("l5_aerr_cleared", 32'(addr_err_p), 32'd0);
        send_bytes(0, 5, 1'b0, 1'b1);
        wait_done("l5_done");
        check("l5_raw_writes", 32'(tot_r - mark_r), 32'd2);
        check("l5_raw_word0", rw(0), 32'hb3b2_b1b0);
        check("l5_raw_word1", rw(1), 32'h0000_00b4);
        check("l5_pad_word1", pw(1), 32'h0000_80b4);
        check("l5_pad_writes", 32'(tot_p - mark_p), 32'd16);

        // Reset after 6 bytes discards the partial word
        mark();
        do_start(32'h300);
        send_bytes(0, 6, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mrst_byte_ready", 32'(bus_p.byte_ready), 32'd0);
        check("mrst_we", 32'(bus_p.port_A_we), 32'd0);
        check("mrst_addr", 32'(bus_p.port_A_addr), 32'd0);
        check("mrst_data", bus_p.port_A_data_in, 32'd0);
        check("mrst_msg_size", msg_size_p, 32'd0);
        check("mrst_done", 32'(done_p), 32'd0);
        repeat (20) @(posedge clk);
        #1;
        check("mrst_writes", 32'(tot_p - mark_p), 32'd1);
        check("mrst_word0", pw(0), 32'hb3b2_b1b0);
        check("mrst_still_idle", 32'(bus_p.byte_ready), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
